fp_mul_seq_core: RTL and testbench

Sequential IEEE-754 single-precision multiply core, the responder to the multiplier control sequencer. Operands are captured on the `Start_Muti` strobe. The 24×24 mantissa product is formed by shift-add over 24 cycles, then normalized and packed. `Done` pulses with a registered result. Latency is fixed and data-independent, so the sequencer's cycle count stays valid for every operand class.

---
 rtl/fp_mul_pkg.sv | 45 ++++
 rtl/fp_mul_seq_core_if.sv | 28 ++
 rtl/fp_mant_shift_add.sv | 58 +++++
 rtl/fp_mul_seq_core.sv | 112 +++++++++++
 tb/tb_fp_mul_seq_core.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/fp_mul_pkg.sv
// Shared definitions for the sequential single-precision multiply core.
// Holds the IEEE-754 field widths, the exponent bias, special-value
// constants, the FSM state encoding, the iteration count and the operand
// classification helper used when operands are captured.
package fp_mul_pkg;

    localparam int MAN_W  = 23;               // stored fraction width
    localparam int EXP_W  = 8;                // exponent width
    localparam int BIAS   = 127;              // exponent bias
    localparam int WORD_W = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 1;        // significand with hidden bit
    localparam int PROD_W = 2 * SIG_W;        // full significand product
    localparam int E_W    = EXP_W + 2;        // signed result-exponent width

    localparam logic [WORD_W-1:0] QNAN     = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0]  EXP_INF  = '1;
    localparam logic [EXP_W-1:0]  EXP_ZERO = '0;

    // One shift-add step per multiplier bit.
    localparam int ITERS = SIG_W;
    localparam int CNT_W = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_PACK = 2'd2;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic             zero;   // exponent 0: true zero or flushed denormal
        logic             inf;
        logic             nan;
    } op_info_t;

    function automatic op_info_t classify(input logic [WORD_W-1:0] x);
        op_info_t info;
        info.sign = x[WORD_W-1];
        info.exp  = x[WORD_W-2 -: EXP_W];
        info.zero = (info.exp == EXP_ZERO);
        info.inf  = (info.exp == EXP_INF) && (x[MAN_W-1:0] == '0);
        info.nan  = (info.exp == EXP_INF) && (x[MAN_W-1:0] != '0);
        return info;
    endfunction

endpackage

// File: rtl/fp_mul_seq_core_if.sv
// Handshake/data bundle between the multiplier control sequencer (master)
// and the multiply core (slave).
//   Start_Muti : start strobe from the sequencer
//   A, B       : operands, sampled on an accepted start
//   Result     : registered product, held until the next Done
//   Done       : one-cycle completion pulse
//   Busy       : core is working on an operation
interface fp_mul_seq_core_if;
    import fp_mul_pkg::*;

    logic              Start_Muti;
    logic [WORD_W-1:0] A;
    logic [WORD_W-1:0] B;
    logic [WORD_W-1:0] Result;
    logic              Done;
    logic              Busy;

    modport master (
        output Start_Muti, A, B,
        input  Result, Done, Busy
    );

    modport slave (
        input  Start_Muti, A, B,
        output Result, Done, Busy
    );

endinterface

// File: rtl/fp_mant_shift_add.sv
// Shift-add significand multiplier. Holds the multiplicand, the multiplier
// and the product accumulator. Each step adds the multiplicand into the
// upper accumulator half when the current multiplier LSB is set, then shifts
// the accumulator and the multiplier right by one.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture operands and clear the accumulator
//   step       : perform one shift-add iteration
//   count_done : marks the current step as the last one
//   mcand_in   : multiplicand significand (hidden bit included)
//   mplier_in  : multiplier significand (hidden bit included)
//   product_hi : product bits [PROD_W-1:MAN_W], the only bits packing needs
module fp_mant_shift_add
    import fp_mul_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    step,
    input  logic                    count_done,
    input  logic [SIG_W-1:0]        mcand_in,
    input  logic [SIG_W-1:0]        mplier_in,
    output logic [PROD_W-1:MAN_W]   product_hi
);

    logic [SIG_W-1:0]  mcand;
    logic [SIG_W-1:0]  mplier;
    logic [PROD_W-1:0] acc;
    logic              complete;
    logic [SIG_W:0]    upper_sum;

    // The carry out of the upper-half add becomes the new MSB after the shift.
    always_comb begin
        upper_sum = {1'b0, acc[PROD_W-1:SIG_W]} + (mplier[0] ? {1'b0, mcand} : '0);
    end

    // Once the final step has run, further steps are ignored so the product
    // stays intact until it is packed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            complete <= 1'b0;
        end else if (load) begin
            mcand    <= mcand_in;
            mplier   <= mplier_in;
            acc      <= '0;
            complete <= 1'b0;
        end else if (step && !complete) begin
            acc      <= {upper_sum, acc[SIG_W-1:1]};
            mplier   <= mplier >> 1;
            complete <= count_done;
        end
    end

    assign product_hi = acc[PROD_W-1:MAN_W];

endmodule

// File: rtl/fp_mul_seq_core.sv
// Sequential IEEE-754 single-precision multiply core. Operands are captured
// on an accepted start, the significand product is built over 24 shift-add
// cycles, and one PACK cycle normalizes, applies special cases and registers
// the result. Latency is 26 cycles regardless of operand values.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : slave side of fp_mul_seq_core_if
//              (Start_Muti, A, B in; Result, Done, Busy out)
module fp_mul_seq_core
    import fp_mul_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    fp_mul_seq_core_if.slave   bus
);

    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;
    op_info_t               info_a;
    op_info_t               info_b;
    logic [WORD_W-1:0]      result_q;
    logic                   done_q;
    logic                   busy_q;
    logic                   accept;
    logic                   count_done;
    logic [PROD_W-1:MAN_W]  prod_hi;

    // Truncating normalize/pack with special-case and range saturation,
    // in priority order.
    function automatic logic [WORD_W-1:0] pack_result(
        input op_info_t              a,
        input op_info_t              b,
        input logic [PROD_W-1:MAN_W] p
    );
        logic                  s;
        logic                  top;
        logic signed [E_W-1:0] e;
        logic [MAN_W-1:0]      frac;
        s    = a.sign ^ b.sign;
        top  = p[PROD_W-1];
        e    = $signed({2'b00, a.exp}) + $signed({2'b00, b.exp})
             - $signed(E_W'(BIAS)) + $signed({{(E_W-1){1'b0}}, top});
        frac = top ? p[PROD_W-2 -: MAN_W] : p[PROD_W-3 -: MAN_W];
        if (a.nan || b.nan || (a.inf && b.zero) || (b.inf && a.zero))
            return QNAN;
        else if (a.inf || b.inf)
            return {s, EXP_INF, {MAN_W{1'b0}}};
        else if (a.zero || b.zero)
            return {s, EXP_ZERO, {MAN_W{1'b0}}};
        else if (e >= $signed(E_W'(EXP_INF)))
            return {s, EXP_INF, {MAN_W{1'b0}}};
        else if (e <= $signed(E_W'(0)))
            return {s, EXP_ZERO, {MAN_W{1'b0}}};
        else
            return {s, e[EXP_W-1:0], frac};
    endfunction

    assign accept     = (state == ST_IDLE) && bus.Start_Muti;
    assign count_done = (cnt == CNT_W'(ITERS - 1));

    fp_mant_shift_add u_mant (
        .clk        (CLK),
        .rst        (RST),
        .load       (accept),
        .step       (state == ST_MUL),
        .count_done (count_done),
        .mcand_in   ({|bus.A[WORD_W-2 -: EXP_W], bus.A[MAN_W-1:0]}),
        .mplier_in  ({|bus.B[WORD_W-2 -: EXP_W], bus.B[MAN_W-1:0]}),
        .product_hi (prod_hi)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            info_a   <= '0;
            info_b   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.Start_Muti) begin
                        info_a <= classify(bus.A);
                        info_b <= classify(bus.B);
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    cnt <= cnt + 1'b1;
                    if (count_done)
                        state <= ST_PACK;
                end
                ST_PACK: begin
                    result_q <= pack_result(info_a, info_b, prod_hi);
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.Result = result_q;
    assign bus.Done   = done_q;
    assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_fp_mul_seq_core.sv
// Bench for fp_mul_seq_core: directed operand pairs followed by random
// operands, each checked cycle by cycle against a reference model of the
// multiply rules (flush-to-zero, truncation, special-value priority).
module tb_fp_mul_seq_core;

    logic        CLK = 1'b0;
    logic        RST;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_result;

    fp_mul_seq_core_if bus ();

    fp_mul_seq_core dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, want);
        end
    endtask

    // Reference: real-number product rules expressed with integer arithmetic.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        int          ea = int'(a[30:23]);
        int          eb = int'(b[30:23]);
        bit          s  = a[31] ^ b[31];
        bit          za = (ea == 0);
        bit          zb = (eb == 0);
        bit          ia = (ea == 255) && (a[22:0] == 0);
        bit          ib = (eb == 255) && (b[22:0] == 0);
        bit          na = (ea == 255) && (a[22:0] != 0);
        bit          nb = (eb == 255) && (b[22:0] != 0);
        logic [47:0] p;
        int          sh;
        int          e;
        if (na || nb || (ia && zb) || (ib && za)) return 32'h7FC0_0000;
        if (ia || ib) return {s, 8'hFF, 23'h0};
        if (za || zb) return {s, 31'h0};
        p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        sh = (p >= 48'h8000_0000_0000) ? 1 : 0;
        e  = ea + eb - 127 + sh;
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), 23'(p >> (23 + sh))};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] x = $urandom;
        case ($urandom_range(0, 7))
            0: x[30:23] = 8'h00;
            1: begin
                x[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 1) x[22:0] = '0;
            end
            2: x[30:23] = 8'($urandom_range(190, 254));
            3: x[30:23] = 8'($urandom_range(1, 64));
            default: x[30:23] = 8'($urandom_range(100, 154));
        endcase
        return x;
    endfunction

    // Starts an operation in the current cycle (cycle 0) and follows it
    // through cycle 26. A second start may be pulsed in cycle inj (0 = none).
    // Returns in cycle 26, so a following call starts back-to-back.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int inj, input string tag);
        logic [31:0] want = model(a, b);
        bus.A          = a;
        bus.B          = b;
        bus.Start_Muti = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                bus.Start_Muti = 1'b0;
                bus.A = $urandom;
                bus.B = $urandom;
            end
            if (c == inj) begin
                bus.Start_Muti = 1'b1;
                bus.A = 32'h3F80_0000;
                bus.B = 32'h3F80_0000;
            end else if (inj != 0 && c == inj + 1) begin
                bus.Start_Muti = 1'b0;
            end
            check($sformatf("%s busy c%0d", tag, c), {31'b0, bus.Busy}, {31'b0, c <= 25});
            check($sformatf("%s done c%0d", tag, c), {31'b0, bus.Done}, {31'b0, c == 26});
            if (c < 26)
                check($sformatf("%s hold c%0d", tag, c), bus.Result, last_result);
        end
        check({tag, " result"}, bus.Result, want);
        last_result = want;
    endtask

    initial begin
        RST            = 1'b1;
        bus.Start_Muti = 1'b0;
        bus.A          = '0;
        bus.B          = '0;
        last_result    = '0;

        @(negedge CLK);
        check("reset result", bus.Result, 32'h0);
        check("reset done", {31'b0, bus.Done}, 32'h0);
        check("reset busy", {31'b0, bus.Busy}, 32'h0);
        RST = 1'b0;
        @(negedge CLK);
        check("idle busy", {31'b0, bus.Busy}, 32'h0);

        // Directed operands, all back-to-back.
        run_op(32'h3FC0_0000, 32'h4000_0000, 0, "1p5x2");
        run_op(32'hC000_0000, 32'h4040_0000, 0, "m2x3");
        run_op(32'h3F80_0000, 32'h3F80_0000, 0, "1x1");
        run_op(32'h0000_0000, 32'h7F7F_FFFF, 0, "0xmax");
        run_op(32'h8000_0000, 32'h3F80_0000, 0, "m0x1");
        run_op(32'h0000_0001, 32'h3F80_0000, 0, "denx1");
        run_op(32'h7F00_0000, 32'h7F00_0000, 0, "ovf");
        run_op(32'h0080_0000, 32'h0080_0000, 0, "unf");
        run_op(32'h7F80_0000, 32'h0000_0000, 0, "infx0");
        run_op(32'hFF80_0000, 32'h4000_0000, 0, "minfx2");
        run_op(32'h7FC1_2345, 32'h3F80_0000, 0, "nanx1");
        run_op(32'h3FFF_FFFF, 32'h3FFF_FFFF, 0, "trunc");
        run_op(32'h4000_0000, 32'h4000_0000, 10, "ignstart");
        run_op(32'h4040_0000, 32'h4040_0000, 0, "chained");

        // Reset in cycle 12 of an operation discards it.
        bus.A          = 32'h4000_0000;
        bus.B          = 32'h4040_0000;
        bus.Start_Muti = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge CLK);
            bus.Start_Muti = 1'b0;
        end
        #2 RST = 1'b1;
        #1;
        check("async rst busy", {31'b0, bus.Busy}, 32'h0);
        check("async rst done", {31'b0, bus.Done}, 32'h0);
        check("async rst result", bus.Result, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        last_result = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            check($sformatf("post rst done c%0d", c), {31'b0, bus.Done}, 32'h0);
            check($sformatf("post rst busy c%0d", c), {31'b0, bus.Busy}, 32'h0);
        end
        run_op(32'h4000_0000, 32'h4040_0000, 0, "after rst");

        // Random operands with a mix of classes and exponent ranges.
        for (int i = 0; i < 40; i++)
            run_op(rand_operand(), rand_operand(), 0, $sformatf("rnd%0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
